// File: rtl/shadow_flag_stack_if.sv
// Flag-stack request/status bundle between the interrupt/control unit
// (master) and the shadow flag stack (slave).
interface shadow_flag_stack_if #(
   parameter int NUM_FLAGS = 2,
   parameter int DEPTH     = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NUM_FLAGS-1:0] FLG_IN;
   logic                 FLG_SHAD_LD;
   logic                 FLG_SHAD_POP;
   logic                 ERR_CLR;
   logic [NUM_FLAGS-1:0] SHAD_FLG;
   logic [CW-1:0]        COUNT;
   logic                 EMPTY;
   logic                 FULL;
   logic                 OVF;
   logic                 UNF;

   modport master (
      output FLG_IN, FLG_SHAD_LD, FLG_SHAD_POP, ERR_CLR,
      input  SHAD_FLG, COUNT, EMPTY, FULL, OVF, UNF
   );

   modport slave (
      input  FLG_IN, FLG_SHAD_LD, FLG_SHAD_POP, ERR_CLR,
      output SHAD_FLG, COUNT, EMPTY, FULL, OVF, UNF
   );
endinterface

// File: rtl/shadow_flag_stack.sv
// LIFO of NUM_FLAGS-wide flag snapshots for nested interrupts; the top entry
// feeds the flag-restore mux. Circular storage addressed by base + count.
module shadow_flag_stack #(
   parameter int NUM_FLAGS = 2,
   parameter int DEPTH     = 4,
   parameter int OVF_MODE  = 0
) (
   input  logic                 clk,
   input  logic                 RST_N,
   shadow_flag_stack_if.slave   bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [NUM_FLAGS-1:0] mem_q [DEPTH];
   logic [NUM_FLAGS-1:0] mem_d [DEPTH];
   logic [IW-1:0]        base_q, base_d;
   logic [CW-1:0]        cnt_q,  cnt_d;
   logic                 ovf_q,  ovf_d;
   logic                 unf_q,  unf_d;

   logic [IW-1:0]        top_idx;
   logic [IW-1:0]        nxt_idx;
   logic                 is_empty;
   logic                 is_full;

   // DEPTH may be non-power-of-two, so wrap by compare-and-subtract.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a,
                                              input logic [CW-1:0] b);
      logic [CW:0] s;
      s = (CW+1)'(a) + (CW+1)'(b);
      if (s >= (CW+1)'(DEPTH))
         s = s - (CW+1)'(DEPTH);
      return IW'(s);
   endfunction

   assign is_empty = (cnt_q == '0);
   assign is_full  = (cnt_q == DEPTH_C);
   assign top_idx  = is_empty ? '0 : wrap_add(base_q, cnt_q - CW'(1));
   assign nxt_idx  = wrap_add(base_q, cnt_q);

   always_comb begin
      mem_d  = mem_q;
      base_d = base_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q & ~bus.ERR_CLR;
      unf_d  = unf_q & ~bus.ERR_CLR;

      if (bus.FLG_SHAD_LD && bus.FLG_SHAD_POP && !is_empty) begin
         // Return-then-reenter: replace the top in place, never an overflow.
         mem_d[top_idx] = bus.FLG_IN;
      end else if (bus.FLG_SHAD_LD) begin
         if (!is_full) begin
            mem_d[nxt_idx] = bus.FLG_IN;
            cnt_d          = cnt_q + CW'(1);
         end else begin
            ovf_d = 1'b1;
            if (OVF_MODE == 1) begin
               mem_d[base_q] = bus.FLG_IN;
               base_d        = wrap_add(base_q, CW'(1));
            end
         end
      end else if (bus.FLG_SHAD_POP) begin
         if (!is_empty)
            cnt_d = cnt_q - CW'(1);
         else
            unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         base_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= mem_d[i];
         base_q <= base_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   assign bus.SHAD_FLG = is_empty ? '0 : mem_q[top_idx];
   assign bus.COUNT    = cnt_q;
   assign bus.EMPTY    = is_empty;
   assign bus.FULL     = is_full;
   assign bus.OVF      = ovf_q;
   assign bus.UNF      = unf_q;
endmodule

// File: tb/tb_shadow_flag_stack.sv
// Directed scoreboard bench: stimulus queues hand-computed expectations, a
// monitor pops and compares one cycle snapshot after each sampling edge.
module tb_shadow_flag_stack;
   logic clk;
   logic RST_N;

   shadow_flag_stack_if #(.NUM_FLAGS(2), .DEPTH(4)) if0 ();
   shadow_flag_stack_if #(.NUM_FLAGS(2), .DEPTH(4)) if1 ();

   shadow_flag_stack #(.NUM_FLAGS(2), .DEPTH(4), .OVF_MODE(0)) dut0 (
      .clk(clk), .RST_N(RST_N), .bus(if0.slave));
   shadow_flag_stack #(.NUM_FLAGS(2), .DEPTH(4), .OVF_MODE(1)) dut1 (
      .clk(clk), .RST_N(RST_N), .bus(if1.slave));

   typedef struct {
      int         sel;
      logic [1:0] shad;
      logic [2:0] cnt;
      logic       ovf;
      logic       unf;
      string      name;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   nvec = 0;
   int   nerr = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_state(input int sel, input string nm, input logic [1:0] shad,
                              input logic [2:0] cnt, input logic ovf, input logic unf);
      logic [1:0] a_shad;
      logic [2:0] a_cnt;
      logic       a_emp, a_full, a_ovf, a_unf;
      a_shad = sel ? if1.SHAD_FLG : if0.SHAD_FLG;
      a_cnt  = sel ? if1.COUNT    : if0.COUNT;
      a_emp  = sel ? if1.EMPTY    : if0.EMPTY;
      a_full = sel ? if1.FULL     : if0.FULL;
      a_ovf  = sel ? if1.OVF      : if0.OVF;
      a_unf  = sel ? if1.UNF      : if0.UNF;
      cmp({nm, ".shad"},  8'(a_shad), 8'(shad));
      cmp({nm, ".count"}, 8'(a_cnt),  8'(cnt));
      cmp({nm, ".empty"}, 8'(a_emp),  8'(cnt == 3'd0));
      cmp({nm, ".full"},  8'(a_full), 8'(cnt == 3'd4));
      cmp({nm, ".ovf"},   8'(a_ovf),  8'(ovf));
      cmp({nm, ".unf"},   8'(a_unf),  8'(unf));
   endtask

   // Monitor: one expectation per sampling edge, checked just after it.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check_state(e.sel, e.name, e.shad, e.cnt, e.ovf, e.unf);
      end
   end

   task automatic drive(input int sel, input logic ld, input logic pop,
                        input logic clr, input logic [1:0] flg);
      if (sel == 0) begin
         if0.FLG_SHAD_LD = ld; if0.FLG_SHAD_POP = pop; if0.ERR_CLR = clr; if0.FLG_IN = flg;
      end else begin
         if1.FLG_SHAD_LD = ld; if1.FLG_SHAD_POP = pop; if1.ERR_CLR = clr; if1.FLG_IN = flg;
      end
   endtask

   task automatic step(input int sel, input logic ld, input logic pop, input logic clr,
                       input logic [1:0] flg, input logic [1:0] eshad, input int ecnt,
                       input logic eovf, input logic eunf, input string nm);
      exp_t x;
      drive(sel, ld, pop, clr, flg);
      x.sel = sel; x.shad = eshad; x.cnt = 3'(ecnt); x.ovf = eovf; x.unf = eunf; x.name = nm;
      q.push_back(x);
      @(posedge clk);
      #2;
      drive(sel, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      RST_N = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 2'b00);
      drive(1, 1'b0, 1'b0, 1'b0, 2'b00);
      repeat (2) @(posedge clk);
      #2;
      check_state(0, "rst", 2'b00, 3'd0, 1'b0, 1'b0);
      RST_N = 1'b1;

      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, "idle");

      // basic push / pop
      step(0, 1, 0, 0, 2'b01, 2'b01, 1, 0, 0, "push1");
      step(0, 1, 0, 0, 2'b10, 2'b10, 2, 0, 0, "push2");
      step(0, 1, 0, 0, 2'b11, 2'b11, 3, 0, 0, "push3");
      step(0, 0, 1, 0, 2'b00, 2'b10, 2, 0, 0, "pop1");
      step(0, 0, 1, 0, 2'b00, 2'b01, 1, 0, 0, "pop2");
      step(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, "pop3");

      // overflow, drop mode
      step(0, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0, "d_push0");
      step(0, 1, 0, 0, 2'b01, 2'b01, 2, 0, 0, "d_push1");
      step(0, 1, 0, 0, 2'b10, 2'b10, 3, 0, 0, "d_push2");
      step(0, 1, 0, 0, 2'b11, 2'b11, 4, 0, 0, "d_push3");
      step(0, 1, 0, 0, 2'b01, 2'b11, 4, 1, 0, "d_ovf");
      step(0, 0, 1, 0, 2'b00, 2'b10, 3, 1, 0, "d_pop1");
      step(0, 0, 1, 0, 2'b00, 2'b01, 2, 1, 0, "d_pop2");
      step(0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, "d_pop3");
      step(0, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0, "d_pop4");
      step(0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, "ovf_clr");

      // underflow and clear priority
      step(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, "unf");
      step(0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, "unf_vs_clr");
      step(0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, "unf_clr");

      // simultaneous push and pop
      step(0, 1, 0, 0, 2'b11, 2'b11, 1, 0, 0, "s_push1");
      step(0, 1, 0, 0, 2'b10, 2'b10, 2, 0, 0, "s_push2");
      step(0, 1, 1, 0, 2'b01, 2'b01, 2, 0, 0, "s_replace");
      step(0, 0, 1, 0, 2'b00, 2'b11, 1, 0, 0, "s_pop1");
      step(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, "s_pop2");
      step(0, 1, 1, 0, 2'b11, 2'b11, 1, 0, 0, "s_empty_both");
      step(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, "s_pop3");

      // replace while full never overflows
      step(0, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0, "f_push0");
      step(0, 1, 0, 0, 2'b01, 2'b01, 2, 0, 0, "f_push1");
      step(0, 1, 0, 0, 2'b10, 2'b10, 3, 0, 0, "f_push2");
      step(0, 1, 0, 0, 2'b11, 2'b11, 4, 0, 0, "f_push3");
      step(0, 1, 1, 0, 2'b01, 2'b01, 4, 0, 0, "f_replace");
      step(0, 0, 1, 0, 2'b00, 2'b10, 3, 0, 0, "f_pop1");
      step(0, 0, 1, 0, 2'b00, 2'b01, 2, 0, 0, "f_pop2");
      step(0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0, "f_pop3");
      step(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, "f_pop4");

      // asynchronous reset mid-stack
      step(0, 1, 0, 0, 2'b01, 2'b01, 1, 0, 0, "r_push1");
      step(0, 1, 0, 0, 2'b10, 2'b10, 2, 0, 0, "r_push2");
      step(0, 1, 0, 0, 2'b11, 2'b11, 3, 0, 0, "r_push3");
      RST_N = 1'b0;
      #1;
      check_state(0, "async_rst", 2'b00, 3'd0, 1'b0, 1'b0);
      #2;
      RST_N = 1'b1;
      @(posedge clk);
      #2;
      step(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, "post_rst");

      // overflow, circular mode
      step(1, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0, "c_push0");
      step(1, 1, 0, 0, 2'b01, 2'b01, 2, 0, 0, "c_push1");
      step(1, 1, 0, 0, 2'b10, 2'b10, 3, 0, 0, "c_push2");
      step(1, 1, 0, 0, 2'b11, 2'b11, 4, 0, 0, "c_push3");
      step(1, 1, 0, 0, 2'b01, 2'b01, 4, 1, 0, "c_ovf");
      step(1, 0, 1, 0, 2'b00, 2'b11, 3, 1, 0, "c_pop1");
      step(1, 0, 1, 0, 2'b00, 2'b10, 2, 1, 0, "c_pop2");
      step(1, 0, 1, 0, 2'b00, 2'b01, 1, 1, 0, "c_pop3");
      step(1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0, "c_pop4");
      step(1, 1, 0, 0, 2'b10, 2'b10, 1, 1, 0, "c_wrap_push");
      step(1, 0, 0, 1, 2'b00, 2'b10, 1, 0, 0, "c_clr");

      repeat (2) @(posedge clk);
      #3;
      if (q.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/shadow_flag_stack.md
Name: shadow_flag_stack

Overview:
- Parametrised successor to the single-bit shadow carry register.
- A LIFO stack of NUM_FLAGS-wide flag snapshots. It holds C, Z and any later flags, nested DEPTH interrupts deep.
- The interrupt/control unit pushes live flags on interrupt entry and pops them on RETIE.
- SHAD_FLG drives the flag-restore mux in front of the flag registers.

Parameters:
NUM_FLAGS, 2, width of one snapshot (bit0 = C, bit1 = Z, higher bits = future flags)
DEPTH, 4, number of snapshot entries (>=2)
OVF_MODE, 0, behaviour of a push when full: 0 = drop the push, 1 = overwrite the oldest entry (circular)

Ports:
clk  in  1  system clock; all state updates on the rising edge
RST_N  in  1  asynchronous active-low reset
FLG_IN  in  NUM_FLAGS  live flags sampled on push
FLG_SHAD_LD  in  1  push request (interrupt entry)
FLG_SHAD_POP  in  1  pop request (RETIE)
ERR_CLR  in  1  synchronous clear of the sticky error flags
SHAD_FLG  out  NUM_FLAGS  top-of-stack snapshot
COUNT  out  $clog2(DEPTH+1)  number of valid entries
EMPTY  out  1  COUNT == 0
FULL  out  1  COUNT == DEPTH
OVF  out  1  sticky: a push was attempted while full
UNF  out  1  sticky: a pop was attempted while empty

Behaviour:
- Reset (RST_N low, asynchronous):
  - Entries, base pointer and COUNT go to 0.
  - SHAD_FLG = 0, EMPTY = 1, FULL = 0, OVF = 0, UNF = 0.
  - Reset asserted mid-operation discards all entries immediately. The clock edge coincident with deassertion performs no operation.
- Storage:
  - Register array plus base pointer (oldest entry) and COUNT.
  - Top index = (base + COUNT - 1) mod DEPTH.
  - All outputs are combinational from registers. SHAD_FLG = entry[top] when COUNT > 0, otherwise all zeros.
- Latency: a push or pop is reflected on SHAD_FLG, COUNT, EMPTY and FULL in the cycle after the edge that samples the request.
- Push only, not full:
  - entry[(base + COUNT) mod DEPTH] <= FLG_IN.
  - COUNT += 1.
- Push only, full:
  - Always sets OVF.
  - OVF_MODE = 0: no state change; the snapshot is lost.
  - OVF_MODE = 1: entry[base] <= FLG_IN, base <= (base + 1) mod DEPTH, COUNT stays DEPTH. The oldest entry is discarded and the new one becomes the top.
- Pop only, not empty: COUNT -= 1. Entry contents are not cleared.
- Pop only, empty: no state change, UNF set, SHAD_FLG stays 0.
- Push and pop in the same cycle:
  - COUNT > 0: entry[top] <= FLG_IN, COUNT unchanged. This is a replace and never sets OVF, even when full.
  - COUNT == 0: treated as push only (COUNT becomes 1). UNF is not set.
- Pointer arithmetic: base and all indices wrap modulo DEPTH. DEPTH need not be a power of two, so the wrap uses explicit compare-and-reset, not bit truncation.
- Sticky errors:
  - OVF and UNF stay set until ERR_CLR or reset.
  - When ERR_CLR coincides with a new error event in the same cycle, the new event wins and the flag remains 1.
- Idle (no request): all state held, including across arbitrary idle cycles.
- Invariants: COUNT <= DEPTH at all times. FULL and EMPTY are never both 1.

Test Plan:
- Reset then idle 5 cycles -> SHAD_FLG = 00, COUNT = 0, EMPTY = 1, FULL = 0, OVF = UNF = 0; assert RST_N low mid-stack with COUNT = 3 -> all return to reset values immediately, without waiting for a clock edge.
- Push 01, 10, 11 on consecutive cycles -> after each edge SHAD_FLG = 01, 10, 11 and COUNT = 1, 2, 3; then pop 3 times -> SHAD_FLG = 10, 01, 00, with EMPTY = 1 after the third pop.
- OVF_MODE = 0, DEPTH = 4: push 00, 01, 10, 11 (FULL = 1), then push 01 -> OVF = 1, SHAD_FLG = 11, COUNT = 4; pop 4 times -> SHAD_FLG sequence 10, 01, 00, 00.
- OVF_MODE = 1, DEPTH = 4: same stimulus -> OVF = 1, SHAD_FLG = 01, COUNT = 4; pop 4 times -> 11, 10, 01, then 00 with EMPTY = 1.
- Pop when empty -> UNF = 1, COUNT = 0; pop again with ERR_CLR = 1 -> UNF stays 1; next cycle ERR_CLR alone -> UNF = 0.
- Simultaneous push and pop:
  - with COUNT = 2, top = 10, FLG_IN = 01 -> COUNT = 2, SHAD_FLG = 01;
  - with COUNT = 0, FLG_IN = 11 -> COUNT = 1, SHAD_FLG = 11, UNF = 0;
  - with FULL = 1 -> top replaced, OVF stays 0.
